// File: rtl/div_pkg.sv
// Shared types and constants for the div_seq_32 sequential divider.
// neg_prefix is only built when DIV_SIGNED_EN is defined.
package div_pkg;
   localparam int W     = 32;
   localparam int CNT_W = 5;
   localparam logic [CNT_W-1:0] ITER_LAST = 5'd31;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      FIN  = 2'd3
   } state_e;

`ifdef DIV_SIGNED_EN
   // Two's-complement negate without a carry chain: keep bits up to the lowest one, invert above it.
   function automatic logic [W-1:0] neg_prefix(input logic [W-1:0] v);
      logic [W-1:0] res;
      logic         seen;
      seen = 1'b0;
      for (int i = 0; i < W; i++) begin
         res[i] = v[i] ^ seen;
         seen   = seen | v[i];
      end
      return res;
   endfunction
`endif
endpackage

// File: rtl/div_seq_32_if.sv
// Issue-side handshake and operand/result bus of the div_seq_32 divider.
interface div_seq_32_if;
   import div_pkg::*;

   logic         start;
   logic         is_signed;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic [W-1:0] q;
   logic [W-1:0] r;
   logic         busy;
   logic         done;
   logic         dz;

   modport master (
      output start, is_signed, dividend, divisor,
      input  q, r, busy, done, dz
   );

   modport slave (
      input  start, is_signed, dividend, divisor,
      output q, r, busy, done, dz
   );
endinterface

// File: rtl/div_seq_32_addsub.sv
// 32-bit add/subtract datapath (RC_ADD_SUB_32): sna=1 gives y=a-b with co=1 meaning no borrow.
module div_seq_32_addsub
   import div_pkg::*;
(
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sna,
   output logic [W-1:0] y,
   output logic         co
);
   logic [W-1:0] b_x_s;
   logic [W:0]   sum_s;

   // Subtract is add of the inverted operand with carry-in set.
   always_comb begin
      b_x_s = b ^ {W{sna}};
      sum_s = {1'b0, a} + {1'b0, b_x_s} + {{W{1'b0}}, sna};
      y     = sum_s[W-1:0];
      co    = sum_s[W];
   end
endmodule

// File: rtl/div_seq_32.sv
// Multi-cycle restoring divider, one quotient bit per clock, START/BUSY/DONE handshake.
// Define DIV_SIGNED_EN to honour is_signed (magnitude capture plus sign fix-up in FIX).
module div_seq_32
   import div_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   div_seq_32_if.slave  bus
);
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     rem_q, rem_d;
   logic [W-1:0]     quo_q, quo_d;
   logic [W-1:0]     dvsr_q, dvsr_d;
   logic             dz_flag_q, dz_flag_d;
   logic [W-1:0]     q_q, q_d;
   logic [W-1:0]     r_q, r_d;
   logic             dz_q, dz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifdef DIV_SIGNED_EN
   logic             neg_q_q, neg_q_d;
   logic             neg_r_q, neg_r_d;
   logic [W-1:0]     orig_q, orig_d;
`endif

   logic [W:0]       p_s;
   logic [W-1:0]     add_a_s, add_b_s, add_y_s;
   logic             add_sna_s, add_co_s;

   assign p_s = {rem_q, quo_q[W-1]};

   // Shared adder operands: trial subtract in CALC, remainder negation in FIX.
   always_comb begin
      add_a_s   = p_s[W-1:0];
      add_b_s   = dvsr_q;
      add_sna_s = 1'b1;
`ifdef DIV_SIGNED_EN
      if (state_q == FIX) begin
         add_a_s = {W{1'b0}};
         add_b_s = rem_q;
      end else begin
         add_a_s = p_s[W-1:0];
         add_b_s = dvsr_q;
      end
`endif
   end

   div_seq_32_addsub u_addsub (
      .a   (add_a_s),
      .b   (add_b_s),
      .sna (add_sna_s),
      .y   (add_y_s),
      .co  (add_co_s)
   );

   // Next-state, datapath and result logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvsr_d    = dvsr_q;
      dz_flag_d = dz_flag_q;
      q_d       = q_q;
      r_d       = r_q;
      dz_d      = dz_q;
`ifdef DIV_SIGNED_EN
      neg_q_d   = neg_q_q;
      neg_r_d   = neg_r_q;
      orig_d    = orig_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d   = CALC;
               cnt_d     = {CNT_W{1'b0}};
               rem_d     = {W{1'b0}};
               quo_d     = bus.dividend;
               dvsr_d    = bus.divisor;
               dz_flag_d = (bus.divisor == {W{1'b0}});
`ifdef DIV_SIGNED_EN
               orig_d  = bus.dividend;
               neg_q_d = bus.is_signed & (bus.dividend[W-1] ^ bus.divisor[W-1]);
               neg_r_d = bus.is_signed & bus.dividend[W-1];
               if (bus.is_signed && bus.dividend[W-1]) begin
                  quo_d = neg_prefix(bus.dividend);
               end else begin
                  quo_d = bus.dividend;
               end
               if (bus.is_signed && bus.divisor[W-1]) begin
                  dvsr_d = neg_prefix(bus.divisor);
               end else begin
                  dvsr_d = bus.divisor;
               end
`endif
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            // P[32] set means the trial subtract cannot underflow even if co says borrow.
            if (p_s[W] || add_co_s) begin
               rem_d = add_y_s;
               quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
               rem_d = p_s[W-1:0];
               quo_d = {quo_q[W-2:0], 1'b0};
            end
            if (cnt_q == ITER_LAST) begin
               state_d = FIX;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         FIX: begin
            state_d = FIN;
            dz_d    = dz_flag_q;
            q_d     = quo_q;
            r_d     = rem_q;
`ifdef DIV_SIGNED_EN
            if (dz_flag_q) begin
               q_d = {W{1'b1}};
               r_d = orig_q;
            end else begin
               if (neg_q_q) begin
                  q_d = neg_prefix(quo_q);
               end else begin
                  q_d = quo_q;
               end
               if (neg_r_q) begin
                  r_d = add_y_s;
               end else begin
                  r_d = rem_q;
               end
            end
`endif
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == CALC) || (state_d == FIX);
      done_d = (state_d == FIN);
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= {CNT_W{1'b0}};
         rem_q     <= {W{1'b0}};
         quo_q     <= {W{1'b0}};
         dvsr_q    <= {W{1'b0}};
         dz_flag_q <= 1'b0;
         q_q       <= {W{1'b0}};
         r_q       <= {W{1'b0}};
         dz_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
         neg_q_q   <= 1'b0;
         neg_r_q   <= 1'b0;
         orig_q    <= {W{1'b0}};
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvsr_q    <= dvsr_d;
         dz_flag_q <= dz_flag_d;
         q_q       <= q_d;
         r_q       <= r_d;
         dz_q      <= dz_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef DIV_SIGNED_EN
         neg_q_q   <= neg_q_d;
         neg_r_q   <= neg_r_d;
         orig_q    <= orig_d;
`endif
      end
   end

   assign bus.q    = q_q;
   assign bus.r    = r_q;
   assign bus.dz   = dz_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
endmodule

// File: tb/tb_div_seq_32.sv
// Scoreboard bench for div_seq_32: random and directed divisions against an arithmetic model.
module tb_div_seq_32;
   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      int          cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   busy_cnt = 0;
   exp_t sb[$];

   div_seq_32_if bus ();

   div_seq_32 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endfunction

   // Reference: plain integer division with the divide-by-zero and overflow rules.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
      exp_t e;
      logic use_signed;
      int   sa;
      int   sd;
      use_signed = 1'b0;
`ifdef DIV_SIGNED_EN
      use_signed = s;
`endif
      e.dz  = (b == 32'd0);
      e.cyc = 0;
      sa = a;
      sd = b;
      if (b == 32'd0) begin
         e.q = 32'hFFFF_FFFF;
         e.r = a;
      end else if (use_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.q = 32'h8000_0000;
         e.r = 32'd0;
      end else if (use_signed) begin
         e.q = sa / sd;
         e.r = sa % sd;
      end else begin
         e.q = a / b;
         e.r = a % b;
      end
      return e;
   endfunction

   // Monitor: pop and compare whenever DONE is presented.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         busy_cnt = 0;
      end else begin
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
               e = sb.pop_front();
               chk("quotient", bus.q, e.q);
               chk("remainder", bus.r, e.r);
               chk("dz", {31'd0, bus.dz}, {31'd0, e.dz});
               chk("latency", cyc, e.cyc + 33);
               chk("busy_cycles", busy_cnt, 33);
            end
            busy_cnt = 0;
         end
      end
   end

   // One division; optional stray START mid-CALC (poke>=0) and in the FIN cycle.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int poke, input bit fin_poke);
      exp_t e;
      int   k;
      @(negedge clk);
      bus.start     = 1'b1;
      bus.dividend  = a;
      bus.divisor   = b;
      bus.is_signed = s;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.dividend = $urandom;
      bus.divisor  = $urandom;
      e     = model(a, b, s);
      e.cyc = cyc;
      sb.push_back(e);
      k = 0;
      while (!bus.done && k < 40) begin
         if (k == poke) begin
            bus.start     = 1'b1;
            bus.dividend  = $urandom;
            bus.divisor   = $urandom_range(1, 9);
            bus.is_signed = ~s;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      bus.start = 1'b0;
      checks++;
      if (!bus.done) begin
         failures++;
         $display("FAIL done_timeout actual=0 required=1 after %0d cycles", k);
      end
      if (fin_poke) begin
         bus.start    = 1'b1;
         bus.dividend = 32'd77;
         bus.divisor  = 32'd3;
         @(negedge clk);
         bus.start = 1'b0;
         chk("fin_start_ignored", {31'd0, bus.busy}, 32'd0);
      end
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.is_signed = 1'b0;
      bus.dividend  = 32'd0;
      bus.divisor   = 32'd0;
      repeat (3) @(negedge clk);
      chk("reset_q", bus.q, 32'd0);
      chk("reset_r", bus.r, 32'd0);
      chk("reset_busy", {31'd0, bus.busy}, 32'd0);
      chk("reset_done", {31'd0, bus.done}, 32'd0);
      chk("reset_dz", {31'd0, bus.dz}, 32'd0);
      rst = 1'b0;

      do_op(32'd100, 32'd7, 1'b0, -1, 1'b1);
      do_op(32'hFFFF_FFFF, 32'd1, 1'b0, -1, 1'b0);
      do_op(32'h0000_0005, 32'h8000_0001, 1'b0, -1, 1'b0);
      do_op(32'h1234_5678, 32'd0, 1'b0, -1, 1'b0);
      do_op(32'hDEAD_BEEF, 32'd13, 1'b0, 10, 1'b0);
      do_op(32'hFFFF_FFF9, 32'd2, 1'b1, -1, 1'b0);
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, 1'b0);
      do_op(32'hFFFF_FF00, 32'd0, 1'b1, -1, 1'b0);

      // Reset in the middle of CALC abandons the operation.
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 32'd999;
      bus.divisor  = 32'd4;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midreset_busy", {31'd0, bus.busy}, 32'd0);
      chk("midreset_q", bus.q, 32'd0);
      chk("midreset_r", bus.r, 32'd0);
      chk("midreset_done", {31'd0, bus.done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      do_op(32'd1000, 32'd33, 1'b0, -1, 1'b0);

      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1, 2:    b = $urandom_range(1, 15);
            3:       b = 32'hFFFF_FFFF - $urandom_range(0, 3);
            4:       b = a >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         do_op(a, b, $urandom_range(0, 1) == 1, -1, 1'b0);
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end
endmodule
